// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: LSB-first frames with runtime-selectable
// length, parity and stop bits, one bit per rising edge of the bclk strobe.
module uart_tx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              bclk,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cfg_bits,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_stop2,
  output logic              tx_data,
  output logic              tx_busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_empty,
  output logic              fifo_full
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  MaxBits = 4'(DATA_W);
  localparam logic [3:0]  MinBits = 4'd5;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e r_state, w_state_d;

  logic              r_bclk_q;
  logic              w_bedge;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push, w_pop;
  logic [DATA_W-1:0] w_head;

  logic [DATA_W-1:0] r_tsr;
  logic [3:0]        r_eff_bits;
  logic [3:0]        r_bit_cnt;
  logic              r_par;
  logic              r_par_en;
  logic              r_stop2;
  logic              r_stop_cnt;
  logic              r_frame_done;

  logic [3:0]        w_eff_bits;
  logic              w_par;
  logic              w_stop_hold;
  logic              w_last_stop;
  logic              w_frame_start;

  // Baud strobe edge detect
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_bclk_q <= 1'b0;
    end else begin
      r_bclk_q <= bclk;
    end
  end

  assign w_bedge = bclk & ~r_bclk_q;

  // FIFO
  assign fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (r_count == '0);
  assign fifo_count = r_count;
  assign in_ready   = ~fifo_full;
  assign w_push     = in_valid & in_ready;
  assign w_pop      = w_frame_start;
  assign w_head     = r_mem[r_rptr];

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame configuration derived from the head word at frame start
  always_comb begin
    if (cfg_bits < MinBits) begin
      w_eff_bits = MinBits;
    end else if (cfg_bits > MaxBits) begin
      w_eff_bits = MaxBits;
    end else begin
      w_eff_bits = cfg_bits;
    end
  end

  always_comb begin
    w_par = cfg_par_odd;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i < 32'(w_eff_bits)) begin
        w_par = w_par ^ w_head[i];
      end
    end
  end

  assign w_stop_hold   = r_stop2 & ~r_stop_cnt;
  assign w_last_stop   = w_bedge & (r_state == StStop) & ~w_stop_hold;
  // A new frame starts from idle, or straight out of the final stop bit
  assign w_frame_start = w_bedge & ~fifo_empty &
                         ((r_state == StIdle) || ((r_state == StStop) && ~w_stop_hold));

  // FSM: state register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_d = r_state;
    if (w_bedge) begin
      case (r_state)
        StIdle: begin
          if (!fifo_empty) begin
            w_state_d = StStart;
          end
        end
        StStart: w_state_d = StData;
        StData: begin
          if (r_bit_cnt == r_eff_bits - 4'd1) begin
            w_state_d = r_par_en ? StParity : StStop;
          end
        end
        StParity: w_state_d = StStop;
        StStop: begin
          if (!w_stop_hold) begin
            w_state_d = fifo_empty ? StIdle : StStart;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    tx_data = 1'b1;
    case (r_state)
      StStart:  tx_data = 1'b0;
      StData:   tx_data = r_tsr[0];
      StParity: tx_data = r_par;
      default:  tx_data = 1'b1;
    endcase
  end

  assign tx_busy    = (r_state != StIdle);
  assign frame_done = r_frame_done;

  // Shift register, counters and latched frame settings
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_tsr        <= '0;
      r_eff_bits   <= MinBits;
      r_bit_cnt    <= '0;
      r_par        <= 1'b0;
      r_par_en     <= 1'b0;
      r_stop2      <= 1'b0;
      r_stop_cnt   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_stop;
      if (w_frame_start) begin
        r_tsr      <= w_head;
        r_eff_bits <= w_eff_bits;
        r_par      <= w_par;
        r_par_en   <= cfg_par_en;
        r_stop2    <= cfg_stop2;
      end else if (w_bedge) begin
        case (r_state)
          StStart: begin
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
          end
          StData: begin
            r_tsr     <= {1'b0, r_tsr[DATA_W-1:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
          StStop: begin
            if (w_stop_hold) begin
              r_stop_cnt <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an input FIFO and a valid/ready handshake. Data length, parity and stop-bit count are configurable at runtime. The block serialises bytes onto tx_data, LSB first, advancing one bit per rising edge of the baud-rate strobe bclk. It sits between the CPU/register-side producer and the pad, and sends frames back-to-back with no idle gap while the FIFO holds data.

Parameters:
DATA_W, 8, maximum data bits per frame and FIFO word width (5..9).
FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count.

Ports:
sys_clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  reset, asynchronous, active-high.
bclk  in  1  baud strobe, already synchronous to sys_clk; each rising edge is one bit period.
in_data  in  DATA_W  word to enqueue.
in_valid  in  1  producer offers in_data.
in_ready  out  1  FIFO can accept; equals !fifo_full.
cfg_bits  in  4  data bits per frame; sampled at frame start.
cfg_par_en  in  1  append a parity bit; sampled at frame start.
cfg_par_odd  in  1  1 = odd parity, 0 = even; sampled at frame start.
cfg_stop2  in  1  1 = two stop bits, 0 = one; sampled at frame start.
tx_data  out  1  serial line; idles high.
tx_busy  out  1  high whenever the state is not IDLE.
frame_done  out  1  one-sys_clk pulse when the final stop bit ends.
fifo_count  out  CNT_W  current FIFO occupancy.
fifo_empty  out  1  occupancy is 0.
fifo_full  out  1  occupancy is FIFO_DEPTH.

Behaviour:
- Reset values: all state is cleared. tx_data=1, tx_busy=0, frame_done=0, fifo_count=0, fifo_empty=1, fifo_full=0, in_ready=1.
- Reset asserted mid-frame: tx_data returns high immediately (combinational from state IDLE) and FIFO contents are discarded.
- Baud edge detection: bedge = bclk & ~bclk_q, where bclk_q is registered. All state transitions happen only on sys_clk cycles where bedge=1.
- FIFO push: occurs when in_valid && in_ready. in_ready depends only on fifo_full, never on a same-cycle pop.
- FIFO pop: occurs only at frame start.
- Simultaneous push and pop: count is unchanged; ordering is preserved.
- Pointers wrap modulo FIFO_DEPTH.
- Effective bit count: eff_bits = cfg_bits clamped to [5, DATA_W]. Values below 5 become 5; values above DATA_W become DATA_W.
- Frame start: pop the FIFO into shift register TSR and latch eff_bits, par_en, par_odd and stop2. Parity is latched as XOR of TSR[eff_bits-1:0], inverted when par_odd=1. Config changes mid-frame have no effect.
- States and line values (tx_data):
  IDLE: line 1. On bedge, if !fifo_empty: frame start, go to START.
  START: line 0. On bedge go to DATA, bit counter = 0.
  DATA: line TSR[0]. On bedge shift TSR right and increment the counter. When counter == eff_bits-1, go to PARITY if par_en, else STOP.
  PARITY: line = latched parity bit. On bedge go to STOP, stop counter = 0.
  STOP: line 1. On bedge, if stop2 and stop counter == 0, increment the counter and stay in STOP. Otherwise pulse frame_done, then:
    if !fifo_empty: frame start, go directly to START (back-to-back);
    else: go to IDLE.
- Latency: a word pushed into an empty, idle block drives tx_data low on the sys_clk after the next bedge. Each bit lasts exactly one bclk period.
- Bits of in_data at or above eff_bits are ignored.
- bclk held low: the state machine freezes and the FIFO still accepts pushes.

Test Plan:
- Reset, then push 0xA5 with cfg 8N1 -> line per bclk edge: 0,1,0,1,0,0,1,0,1,1, then idle 1. frame_done pulses once; tx_busy falls after the stop bit.
- 0xA5 with 8E1, then 8O1 -> parity bit is 0 for even and 1 for odd. Frames are 11 bit-times each.
- cfg_bits=7, even parity, 2 stop bits, push 0xFF -> 0, seven 1s, parity 1, stop 1, stop 1 (bit 7 ignored). cfg_bits=2 behaves as 5.
- Push 5 words with FIFO_DEPTH=4 while bclk is stalled -> 4 accepted, in_ready=0 and fifo_full=1, 5th held off. Release bclk -> four contiguous frames with no idle bit between them, in order; fifo_count decrements at each frame start.
- Push while a pop happens in the same cycle with count=2 -> count stays 2. Flip cfg_par_en mid-frame -> the current frame is unaffected and the next frame uses the new setting.
- Assert rst during the DATA state of a queued 3-word burst -> tx_data=1 and fifo_empty=1 immediately. After release no further frames are sent.
